// File: rtl/fetch_pkg.sv
// Shared state encoding, width defaults and timer width for fetch_sequencer.
// The ERR state only exists when FETCH_TIMEOUT_EN is defined.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned TIMER_W    = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_ACK = 3'd2,
        FETCH    = 3'd3,
        VALID    = 3'd4
`ifdef FETCH_TIMEOUT_EN
        ,
        ERR      = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/ack_timer.sv
// Counts WAIT_ACK cycles for the acknowledge timeout; expired is high during the LIMIT-th counted cycle.
// Only instantiated by fetch_sequencer when FETCH_TIMEOUT_EN is defined.
module ack_timer
    import fetch_pkg::*;
#(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned W     = TIMER_W
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    logic [W-1:0] count;

    // Saturates once expired so a stalled caller never wraps back to "not expired".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC increment handshake, one-cycle memory read, valid/ready hand-off.
// Optional acknowledge timeout with sticky error and ERR state under macro FETCH_TIMEOUT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pc_ack,
    input  logic [ADDR_W-1:0] pc_value,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              instr_ready,
    input  logic              clear_err,
    output logic              pc_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic [7:0]        fetch_count
);

    state_t state;
    state_t state_next;
    logic   armed;
    logic   capture_addr;
    logic   capture_instr;
    logic   accept;

`ifdef FETCH_TIMEOUT_EN
    logic timer_load;
    logic timer_count;
    logic timer_expired;

    ack_timer #(
        .LIMIT (ACK_TIMEOUT),
        .W     (TIMER_W)
    ) u_ack_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .count_en (timer_count),
        .expired  (timer_expired)
    );

    assign timeout_err = (state == ERR);
`else
    logic unused_cfg;
    assign unused_cfg  = &{1'b0, clear_err, ACK_TIMEOUT[0]};
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_en         = 1'b0;
        instr_valid   = 1'b0;
        busy          = (state != IDLE);
        capture_addr  = 1'b0;
        capture_instr = 1'b0;
        accept        = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        timer_load    = 1'b0;
        timer_count   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // armed delays the first request until the second edge after reset release.
                if (start && armed) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                pc_en      = 1'b1;
                state_next = WAIT_ACK;
`ifdef FETCH_TIMEOUT_EN
                timer_load = 1'b1;
`endif
            end
            WAIT_ACK: begin
`ifdef FETCH_TIMEOUT_EN
                timer_count = 1'b1;
`endif
                if (pc_ack) begin
                    capture_addr = 1'b1;
                    state_next   = FETCH;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timer_expired) begin
                    state_next = ERR;
                end
`endif
            end
            FETCH: begin
                capture_instr = 1'b1;
                state_next    = VALID;
            end
            VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    accept     = 1'b1;
                    state_next = start ? REQ : IDLE;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            ERR: begin
                if (clear_err) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed       <= 1'b0;
            imem_addr   <= '0;
            instr       <= '0;
            fetch_count <= '0;
        end else begin
            armed <= 1'b1;
            if (capture_addr) begin
                imem_addr <= pc_value;
            end
            if (capture_instr) begin
                instr <= imem_rdata;
            end
            if (accept) begin
                fetch_count <= fetch_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle comparison against a transaction-level model
// plus literal expectations; timeout scenarios run only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_sequencer;

    localparam int unsigned ACK_TIMEOUT = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       instr_ready = 1'b0;
    logic       clear_err = 1'b0;
    logic       pc_ack;
    logic [7:0] pc_value;
    logic [7:0] imem_rdata;
    logic       pc_en;
    logic [7:0] imem_addr;
    logic [7:0] instr;
    logic       instr_valid;
    logic       busy;
    logic       timeout_err;
    logic [7:0] fetch_count;

    logic       resp_ack = 1'b0;
    logic       spur_ack = 1'b0;
    logic [7:0] resp_pc = 8'h00;
    logic [7:0] mem [256];
    int         ack_delay = 1;
    bit         ack_enable = 1'b1;
    bit         cmp_on = 1'b0;
    int         errors = 0;
    int         checks = 0;

    assign pc_ack     = resp_ack | spur_ack;
    assign pc_value   = spur_ack ? 8'hEE : resp_pc;
    assign imem_rdata = mem[imem_addr];

    fetch_sequencer #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc_ack      (pc_ack),
        .pc_value    (pc_value),
        .imem_rdata  (imem_rdata),
        .instr_ready (instr_ready),
        .clear_err   (clear_err),
        .pc_en       (pc_en),
        .imem_addr   (imem_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".pc_en"}, 32'(pc_en), 0);
        check({tag, ".instr_valid"}, 32'(instr_valid), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".timeout_err"}, 32'(timeout_err), 0);
        check({tag, ".imem_addr"}, 32'(imem_addr), 0);
        check({tag, ".instr"}, 32'(instr), 0);
        check({tag, ".fetch_count"}, 32'(fetch_count), 0);
    endtask

    // Model: which phase of a fetch transaction is in progress, plus the data it carries.
    bit m_req = 0, m_wait = 0, m_fetch = 0, m_valid = 0, m_err = 0, m_settled = 0;
    int m_waited = 0, m_addr = 0, m_instr = 0, m_count = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_req = 0; m_wait = 0; m_fetch = 0; m_valid = 0; m_err = 0; m_settled = 0;
                m_waited = 0; m_addr = 0; m_instr = 0; m_count = 0;
            end else begin : step
                bit was_settled;
                was_settled = m_settled;
                m_settled = 1;
                if (m_valid) begin
                    if (instr_ready) begin
                        m_count = (m_count + 1) % 256;
                        m_valid = 0;
                        m_req = start;
                    end
                end else if (m_fetch) begin
                    m_instr = int'(mem[m_addr]);
                    m_fetch = 0;
                    m_valid = 1;
                end else if (m_wait) begin
                    m_waited = m_waited + 1;
                    if (pc_ack) begin
                        m_addr = int'(pc_value);
                        m_wait = 0;
                        m_fetch = 1;
                    end else if (TO_EN && m_waited == ACK_TIMEOUT) begin
                        m_wait = 0;
                        m_err = 1;
                    end
                end else if (m_req) begin
                    m_req = 0;
                    m_wait = 1;
                    m_waited = 0;
                end else if (m_err) begin
                    if (clear_err) m_err = 0;
                end else if (start && was_settled) begin
                    m_req = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                check("pc_en", 32'(pc_en), 32'(m_req));
                check("instr_valid", 32'(instr_valid), 32'(m_valid));
                check("busy", 32'(busy), 32'(m_req | m_wait | m_fetch | m_valid | m_err));
                check("timeout_err", 32'(timeout_err), 32'(m_err));
                check("imem_addr", 32'(imem_addr), m_addr);
                check("instr", 32'(instr), m_instr);
                check("fetch_count", 32'(fetch_count), m_count);
            end
        end
    end

    // Program-counter stub: acknowledges ack_delay cycles after seeing pc_en, presenting the next PC.
    initial begin
        forever begin
            @(negedge clk);
            if (pc_en && ack_enable) begin
                repeat (ack_delay) @(posedge clk);
                #1 resp_pc = resp_pc + 8'd1;
                resp_ack = 1'b1;
                @(posedge clk);
                #1 resp_ack = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin : stim
        int n;
        int npc;
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[1] = 8'hA5;

        #2 cmp_on = 1'b1;
        do_reset();

        // Basic fetch: addr 01, data A5, valid 4 cycles after start.
        @(posedge clk); #1 start = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("lat.not_yet_valid", 32'(instr_valid), 0);
        @(posedge clk);
        #1 check("lat.valid", 32'(instr_valid), 1);
        check("lat.instr", 32'(instr), 32'h0A5);
        check("lat.addr", 32'(imem_addr), 32'h01);
        check("lat.count_before", 32'(fetch_count), 0);
        start = 1'b0; instr_ready = 1'b1;
        @(posedge clk);
        #1 check("lat.count_after", 32'(fetch_count), 1);
        check("lat.idle", 32'(busy), 0);

        // Backpressure: instr held while instr_ready is low, next pc_en right after accept.
        instr_ready = 1'b0; start = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("bp.instr", 32'(instr), 32'h58);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check("bp.valid_hold", 32'(instr_valid), 1);
            check("bp.no_pc_en", 32'(pc_en), 0);
            check("bp.instr_hold", 32'(instr), 32'h58);
        end
        instr_ready = 1'b1;
        @(posedge clk);
        #1 check("bp.pc_en_next", 32'(pc_en), 1);
        check("bp.count", 32'(fetch_count), 2);
        instr_ready = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);

        // Spurious acknowledge while VALID, then while IDLE.
        #1 spur_ack = 1'b1;
        @(posedge clk);
        #1 spur_ack = 1'b0;
        check("spur_valid.valid", 32'(instr_valid), 1);
        check("spur_valid.addr", 32'(imem_addr), 32'h03);
        instr_ready = 1'b1;
        @(posedge clk);
        #1 instr_ready = 1'b0;
        check("spur_valid.count", 32'(fetch_count), 3);
        spur_ack = 1'b1;
        @(posedge clk);
        #1 spur_ack = 1'b0;
        check("spur_idle.busy", 32'(busy), 0);
        check("spur_idle.addr", 32'(imem_addr), 32'h03);

        // Late acknowledge (third WAIT_ACK cycle); start dropped mid-fetch does not abort it.
        ack_delay = 3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("slow.pc_en", 32'(pc_en), 1);
        repeat (5) @(posedge clk);
        #1 check("slow.valid", 32'(instr_valid), 1);
        check("slow.addr", 32'(imem_addr), 32'h04);
        check("slow.instr", 32'(instr), 32'h5E);
        instr_ready = 1'b1;
        @(posedge clk);
        #1 instr_ready = 1'b0;
        check("slow.count", 32'(fetch_count), 4);
        ack_delay = 1;

        // Start held through reset release: first pc_en only after the second edge.
        start = 1'b1;
        @(posedge clk);
        #1 do_reset();
        @(posedge clk);
        #1 check("rel.edge1_pc_en", 32'(pc_en), 0);
        check("rel.edge1_busy", 32'(busy), 0);
        @(posedge clk);
        #1 check("rel.edge2_pc_en", 32'(pc_en), 1);
        start = 1'b0; instr_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("rel.count", 32'(fetch_count), 1);
        check("rel.idle", 32'(busy), 0);
        instr_ready = 1'b0;

        // Asynchronous reset during VALID.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("rstv.in_valid", 32'(instr_valid), 1);
        #2 do_reset();
        @(posedge clk);

        // Asynchronous reset during WAIT_ACK.
        #1 ack_enable = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("rstw.busy", 32'(busy), 1);
        check("rstw.pc_en", 32'(pc_en), 0);
        #2 do_reset();
        ack_enable = 1'b1;
        @(posedge clk);

        // 256 back-to-back fetches: counter wraps to 0, one pc_en cycle per fetch.
        #1 start = 1'b1; instr_ready = 1'b1;
        n = 0; npc = 0; cyc = 0;
        while (n < 256 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (pc_en) npc++;
            if (instr_valid && instr_ready) begin
                n++;
                if (n == 256) start = 1'b0;
            end
        end
        check("wrap.accepts", n, 256);
        @(posedge clk);
        #1 check("wrap.count", 32'(fetch_count), 0);
        check("wrap.idle", 32'(busy), 0);
        check("wrap.pc_en_cycles", npc, 256);
        instr_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // No acknowledge: ERR after ACK_TIMEOUT WAIT_ACK cycles, cleared by clear_err.
        ack_enable = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("to.wait4_err", 32'(timeout_err), 0);
        @(posedge clk);
        #1 check("to.err", 32'(timeout_err), 1);
        repeat (2) @(posedge clk);
        #1 check("to.sticky", 32'(timeout_err), 1);
        check("to.busy", 32'(busy), 1);
        clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
        check("to.cleared", 32'(timeout_err), 0);
        check("to.idle", 32'(busy), 0);

        // Acknowledge in the fourth WAIT_ACK cycle wins over the timeout.
        ack_enable = 1'b1; ack_delay = 4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; instr_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("to.ack4_err", 32'(timeout_err), 0);
        check("to.ack4_fetch", 32'(busy), 1);
        @(posedge clk);
        #1 check("to.ack4_valid", 32'(instr_valid), 1);
        @(posedge clk);
        #1 instr_ready = 1'b0;
        ack_delay = 1;
`endif

        repeat (2) @(posedge clk);
        #1 cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
